gf8_mul_top: RTL and testbench
==============================

# gf8_mul_top

Self-stimulating GF(2^3) multiplier block. Two independent 3-bit maximal-length LFSRs generate operands `a` and `b` every clock. A carry-less multiplier forms their 5-bit polynomial product `Q` and reduces it modulo the irreducible polynomial x^3+x+1. The reduced field product is registered onto `q`. The block sits at the top of the coursework hierarchy and has no data inputs.

## Interface
- Parameters: none. All constants are fixed in the package.
- `Clk`  input  1  single clock; all state updates on the rising edge.
- `nRst`  input  1  asynchronous reset, active-high (asserted when 1, despite the name).
- `q`  output  3  registered GF(2^3) product of the previous cycle's `a` and `b`.

## Operation
- Operand generator `ran1` (Fibonacci shift-left, polynomial x^3+x^2+1):
  - `a_next = {a[1:0], a[2]^a[1]}`.
  - Seed `3'b001`.
  - Sequence: 1,2,5,3,7,6,4, then repeats.
- Operand generator `ran2` (polynomial x^3+x+1):
  - `b_next = {b[1:0], b[2]^b[0]}`.
  - Seed `3'b111`.
  - Sequence: 7,6,5,2,4,1,3, then repeats.
- Both generators have period 7 and never reach 0; all-zero is unreachable.
- Multiplier `mul1`, combinational from `a` and `b`:
  - `Q[k]` = XOR over i+j=k of `a[i]&b[j]`, for k=0..4.
- Reduction:
  - `q0 = Q0^Q3`
  - `q1 = Q1^Q3^Q4`
  - `q2 = Q2^Q4`
  - These follow from x^3=x+1 and x^4=x^2+x.
- Output register: `q` captures the reduced value on every rising edge while reset is deasserted.
- Hierarchy names `ran1.a`, `ran2.b` and `mul1.Q` are part of the contract; the bench probes them hierarchically.

## Timing
- Reset asserted, asynchronously and at any time including mid-sequence:
  - `a=3'b001`, `b=3'b111`, `q=3'b000` immediately.
  - Held while `nRst=1`.
- First rising edge after release:
  - `q` <= reduce(1·7) = 7.
  - `a`->2, `b`->6.
- Latency: `q` at edge n+1 equals `a`·`b` as they stood after edge n (one cycle).
- `Q` is combinational and settles within the same cycle as `a` and `b`.
- `a` and `b` wrap to their seeds after 7 advancing edges.
- The (a,b) pair sequence therefore has period 7.
- Reset and a clock edge together: reset wins.

## Structure
- Package `gf8_pkg` holds:
  - `typedef logic [2:0] gf8_t`
  - `typedef logic [4:0] gf8_poly_t`
  - `IRRED = 4'b1011` (x^3+x+1)
  - `SEED_A = 3'b001`, `SEED_B = 3'b111`
  - `TAPS_A = 3'b110`, `TAPS_B = 3'b101` (feedback bit = XOR of `state & TAPS`)
  - functions `clmul3` (3x3 carry-less product -> 5 bits) and `gf8_reduce` (5 bits -> 3 bits).
- Sub-module `lfsr3`:
  - Parameterized by `SEED` and `TAPS`.
  - Has the `Clk`/`nRst` ports and output `a`/`b`.
  - Instantiated twice as `ran1` and `ran2`.
- Sub-module `gf8_mul`, instance `mul1`: operands in, internal net `Q`, reduced product out.
- `gf8_mul_top` contains only the instances and the `q` register.

## Test plan
- Reset held 15 ns, then released:
  - During reset: `q=0`, `a=1`, `b=7`, `Q=5'b00111`.
  - After the 1st edge: `q=7`, `a=2`, `b=6`, `Q=5'b01100`.
- 2nd edge: `q=7` (2·6=x^3+x^2≡x^2+x+1); `a=5`, `b=5`, `Q=5'b10001`.
- 3rd edge: `q=7` (5·5=x^4+1≡7); `a=3`, `b=2`, `Q=5'b00110`.
- 4th edge: `q=6`.
- Run 15 edges:
  - `a` and `b` repeat with period 7 and never read 0.
  - `q` at every edge equals `gf8_reduce(clmul3(a,b))` from the prior cycle, checked by the reference model.
- Assert `nRst` asynchronously mid-cycle after 4 edges:
  - `a=1`, `b=7`, `q=0` immediately, without waiting for a clock edge.
  - After release, the sequence restarts exactly as in the first scenario.
- Exhaustive combinational check of `gf8_mul` over all 64 (a,b) pairs against the reference model. Include:
  - 0 annihilates.
  - 1 is the identity.
  - 7·7=3.
  - Commutativity holds for every pair.

Source files
------------

// File: rtl/gf8_pkg.sv
// gf8_pkg
// Shared types and constants for the GF(2^3) multiplier slice.
//   gf8_t       : field element, 3 bits
//   gf8_poly_t  : unreduced carry-less product, 5 bits
//   IRRED       : field polynomial x^3+x+1
//   SEED_*/TAPS_*: operand generator seeds and feedback taps
//   clmul3      : 3x3 carry-less product
//   gf8_reduce  : reduce a 5-bit product modulo IRRED
package gf8_pkg;

    typedef logic [2:0] gf8_t;
    typedef logic [4:0] gf8_poly_t;

    localparam logic [3:0] IRRED  = 4'b1011;
    localparam gf8_t       SEED_A = 3'b001;
    localparam gf8_t       SEED_B = 3'b111;
    localparam gf8_t       TAPS_A = 3'b110;
    localparam gf8_t       TAPS_B = 3'b101;

    function automatic gf8_poly_t clmul3(input gf8_t x, input gf8_t y);
        gf8_poly_t p;
        p = '0;
        for (int i = 0; i < 3; i++) begin
            if (y[i]) p = p ^ (gf8_poly_t'(x) << i);
        end
        return p;
    endfunction

    // Clears bit 4 then bit 3 by folding in shifted copies of IRRED.
    // Equivalent to q0=Q0^Q3, q1=Q1^Q3^Q4, q2=Q2^Q4.
    function automatic gf8_t gf8_reduce(input gf8_poly_t p);
        gf8_poly_t r;
        r = p;
        for (int k = 4; k >= 3; k--) begin
            if (r[k]) r = r ^ (gf8_poly_t'(IRRED) << (k - 3));
        end
        return r[2:0];
    endfunction

endpackage

// File: rtl/gf8_mul_core.sv
// gf8_mul
// Combinational GF(2^3) multiplier: carry-less product Q, then reduction
// modulo x^3+x+1.
// Ports:
//   i_a, i_b : operands
//   o_p      : reduced field product
module gf8_mul
    import gf8_pkg::*;
(
    input  gf8_t i_a,
    input  gf8_t i_b,
    output gf8_t o_p
);

    gf8_poly_t Q;

    assign Q   = clmul3(i_a, i_b);
    assign o_p = gf8_reduce(Q);

endmodule

// File: rtl/gf8_mul_lfsr3.sv
// lfsr3
// 3-bit Fibonacci LFSR, shift-left, feedback = XOR of (state & TAPS).
// Ports:
//   Clk     : clock, rising edge
//   nRst    : asynchronous reset, active-high; loads SEED
//   o_state : current LFSR state
module lfsr3
    import gf8_pkg::*;
#(
    parameter gf8_t SEED = SEED_A,
    parameter gf8_t TAPS = TAPS_A
) (
    input  logic Clk,
    input  logic nRst,
    output gf8_t o_state
);

    // The state is visible as both `a` and `b` so that the instance
    // names ran1.a and ran2.b resolve to the generator state.
    gf8_t a;
    gf8_t b;

    always_ff @(posedge Clk or posedge nRst) begin
        if (nRst) a <= SEED;
        else      a <= {a[1:0], ^(a & TAPS)};
    end

    assign b       = a;
    assign o_state = b;

endmodule

// File: rtl/gf8_mul_top.sv
// gf8_mul_top
// Self-stimulating GF(2^3) multiplier: two LFSRs feed the multiplier and the
// reduced product is registered onto q.
// Ports:
//   Clk  : clock, rising edge
//   nRst : asynchronous reset, active-high (despite the name)
//   q    : registered product of the previous cycle's operands
module gf8_mul_top
    import gf8_pkg::*;
(
    input  logic       Clk,
    input  logic       nRst,
    output logic [2:0] q
);

    gf8_t w_a;
    gf8_t w_b;
    gf8_t w_p;

    lfsr3 #(.SEED(SEED_A), .TAPS(TAPS_A)) ran1 (
        .Clk     (Clk),
        .nRst    (nRst),
        .o_state (w_a)
    );

    lfsr3 #(.SEED(SEED_B), .TAPS(TAPS_B)) ran2 (
        .Clk     (Clk),
        .nRst    (nRst),
        .o_state (w_b)
    );

    gf8_mul mul1 (
        .i_a (w_a),
        .i_b (w_b),
        .o_p (w_p)
    );

    always_ff @(posedge Clk or posedge nRst) begin
        if (nRst) q <= 3'b000;
        else      q <= w_p;
    end

endmodule

// File: tb/tb_gf8_mul_top.sv
// tb_gf8_mul_top
// Directed bench for gf8_mul_top plus a standalone gf8_mul for the
// exhaustive combinational table.
module tb_gf8_mul_top;

    logic       Clk;
    logic       nRst;
    logic [2:0] q;

    logic [2:0] m_a;
    logic [2:0] m_b;
    logic [2:0] m_p;

    int n_total = 0;
    int n_bad   = 0;

    // Hand-derived sequences, index = edges since reset release, mod 7.
    int exp_a [7] = '{1, 2, 5, 3, 7, 6, 4};
    int exp_b [7] = '{7, 6, 5, 2, 4, 1, 3};
    // q after edge n (n>=1) is the product of pair (n-1) mod 7:
    // 1*7=7, 2*6=7, 5*5=7, 3*2=6, 7*4=1, 6*1=6, 4*3=7
    int exp_q [7] = '{7, 7, 7, 6, 1, 6, 7};

    int res [8][8];

    gf8_mul_top dut (
        .Clk  (Clk),
        .nRst (nRst),
        .q    (q)
    );

    gf8_mul u_mul (
        .i_a (m_a),
        .i_b (m_b),
        .o_p (m_p)
    );

    initial Clk = 1'b1;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Shift-and-add with xtime reduction, independent of the RTL formulas.
    function automatic int ref_mul(input int x, input int y);
        int acc;
        int v;
        acc = 0;
        v   = x;
        for (int i = 0; i < 3; i++) begin
            if (((y >> i) & 1) != 0) acc = acc ^ v;
            v = v << 1;
            if ((v & 8) != 0) v = v ^ 11;
        end
        return acc & 7;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_q"}, int'(q), 0);
        chk({tag, "_a"}, int'(dut.ran1.a), 1);
        chk({tag, "_b"}, int'(dut.ran2.b), 7);
        chk({tag, "_Q"}, int'(dut.mul1.Q), 7);
    endtask

    // Runs n edges after a reset release, checking a, b, q against the
    // hand tables and q against the model of the previous operands.
    task automatic run_edges(input string tag, input int n);
        int pa;
        int pb;
        pa = int'(dut.ran1.a);
        pb = int'(dut.ran2.b);
        for (int e = 1; e <= n; e++) begin
            @(posedge Clk);
            #1;
            chk($sformatf("%s_a%0d", tag, e), int'(dut.ran1.a), exp_a[e % 7]);
            chk($sformatf("%s_b%0d", tag, e), int'(dut.ran2.b), exp_b[e % 7]);
            chk($sformatf("%s_q%0d", tag, e), int'(q), exp_q[(e - 1) % 7]);
            chk($sformatf("%s_qm%0d", tag, e), int'(q), ref_mul(pa, pb));
            chk($sformatf("%s_anz%0d", tag, e), int'(dut.ran1.a != 3'd0), 1);
            chk($sformatf("%s_bnz%0d", tag, e), int'(dut.ran2.b != 3'd0), 1);
            if (e == 1) chk($sformatf("%s_Q%0d", tag, e), int'(dut.mul1.Q), 5'b01100);
            if (e == 2) chk($sformatf("%s_Q%0d", tag, e), int'(dut.mul1.Q), 5'b10001);
            if (e == 3) chk($sformatf("%s_Q%0d", tag, e), int'(dut.mul1.Q), 5'b00110);
            pa = int'(dut.ran1.a);
            pb = int'(dut.ran2.b);
        end
    endtask

    initial begin
        nRst = 1'b1;
        m_a  = 3'd0;
        m_b  = 3'd0;

        // Reset held 15 ns; rising edges fall at 10, 20, 30 ...
        #3;
        check_reset_state("rst");
        #12;
        nRst = 1'b0;
        run_edges("s1", 4);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        #3;
        nRst = 1'b1;
        #1;
        check_reset_state("arst");
        @(posedge Clk);
        #1;
        check_reset_state("arst_hold");
        #4;
        nRst = 1'b0;
        run_edges("s2", 15);

        // Exhaustive combinational table.
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                m_a = 3'(x);
                m_b = 3'(y);
                #1;
                res[x][y] = int'(m_p);
                chk($sformatf("mul_%0d_%0d", x, y), res[x][y], ref_mul(x, y));
            end
        end
        for (int x = 0; x < 8; x++) begin
            chk($sformatf("zero_%0d", x), res[0][x], 0);
            chk($sformatf("one_%0d", x), res[1][x], x);
            for (int y = x + 1; y < 8; y++) begin
                chk($sformatf("comm_%0d_%0d", x, y), res[x][y], res[y][x]);
            end
        end
        chk("mul_7_7", res[7][7], 3);
        chk("mul_5_5", res[5][5], 7);
        chk("mul_7_4", res[7][4], 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
